// File: rtl/write_regfile_pkg.sv
// Shared types for the register-file write-back stage: CPU stage encoding
// and the register-index width helper used by every module of this slice.
package write_regfile_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    MEMSTORE  = 2'd3
  } stage_t;

  // Index width for a bank of n registers; a single register still needs one bit.
  function automatic int ridx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_pending_buf.sv
// Pending write buffer: collects port writes between commits, merges them with
// this cycle's port writes (highest port wins) and flags same-index collisions.
module regfile_pending_buf
  import write_regfile_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int DATA_W     = 4,
  parameter int NUM_WPORTS = 2,
  localparam int RIDX_W    = ridx_w(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 n_reset,
  input  logic                                 clr_i,
  input  logic [NUM_WPORTS-1:0]                wr_en_i,
  input  logic [NUM_WPORTS-1:0][RIDX_W-1:0]    wr_addr_i,
  input  logic [NUM_WPORTS-1:0][DATA_W-1:0]    wr_data_i,
  output logic [NUM_REGS-1:0][DATA_W-1:0]      merged_data_o,
  output logic [NUM_REGS-1:0]                  merged_vld_o,
  output logic [NUM_REGS-1:0]                  pend_vld_o,
  output logic                                 conflict_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] pend_data_q, pend_data_d;
  logic [NUM_REGS-1:0]             pend_vld_q, pend_vld_d;
  logic                            conflict_q, conflict_d;
  logic [NUM_REGS-1:0]             hit;
  logic                            conflict_now;

  // Ports are walked in ascending order so a higher-numbered port overrides.
  always_comb begin
    merged_data_o = pend_data_q;
    merged_vld_o  = pend_vld_q;
    hit           = '0;
    conflict_now  = 1'b0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (wr_en_i[p] && (int'(wr_addr_i[p]) < NUM_REGS)) begin
        if (hit[wr_addr_i[p]]) conflict_now = 1'b1;
        hit[wr_addr_i[p]]           = 1'b1;
        merged_data_o[wr_addr_i[p]] = wr_data_i[p];
        merged_vld_o[wr_addr_i[p]]  = 1'b1;
      end
    end
  end

  always_comb begin
    pend_data_d = clr_i ? '0 : merged_data_o;
    pend_vld_d  = clr_i ? '0 : merged_vld_o;
    conflict_d  = conflict_q | conflict_now;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pend_data_q <= '0;
      pend_vld_q  <= '0;
      conflict_q  <= 1'b0;
    end else begin
      pend_data_q <= pend_data_d;
      pend_vld_q  <= pend_vld_d;
      conflict_q  <= conflict_d;
    end
  end

  assign pend_vld_o = pend_vld_q;
  assign conflict_o = conflict_q;

endmodule

// File: rtl/write_regfile.sv
// Register-file write-back stage: commits buffered writes into cur on MEMSTORE.
// Optional shadow bank for save/restore is enabled by WRITE_REGFILE_SHADOW_EN.
module write_regfile
  import write_regfile_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int DATA_W     = 4,
  parameter int NUM_WPORTS = 2,
  parameter int CNT_W      = 8,
  localparam int RIDX_W    = ridx_w(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              n_reset,
  input  stage_t                            stage,
  input  logic [NUM_WPORTS-1:0]             wr_en,
  input  logic [NUM_WPORTS-1:0][RIDX_W-1:0] wr_addr,
  input  logic [NUM_WPORTS-1:0][DATA_W-1:0] wr_data,
  input  logic                              flush,
`ifdef WRITE_REGFILE_SHADOW_EN
  input  logic                              save,
  input  logic                              restore,
`endif
  output logic [NUM_REGS-1:0][DATA_W-1:0]   cur,
  output logic [NUM_REGS-1:0]               pending_vld,
  output logic                              conflict,
  output logic [CNT_W-1:0]                  commit_cnt
);

  logic [NUM_REGS-1:0][DATA_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] merged_data;
  logic [NUM_REGS-1:0]             merged_vld;
  logic                            is_commit;
  logic                            clr;
  logic                            restore_w;

`ifdef WRITE_REGFILE_SHADOW_EN
  logic [NUM_REGS-1:0][DATA_W-1:0] shadow_q, shadow_d;

  assign restore_w = restore;

  // Shadow captures the pre-edge cur, so save+restore swaps the two banks.
  always_comb shadow_d = save ? cur_q : shadow_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) shadow_q <= '0;
    else          shadow_q <= shadow_d;
  end
`else
  logic [NUM_REGS-1:0][DATA_W-1:0] shadow_q;

  assign restore_w = 1'b0;
  assign shadow_q  = '0;
`endif

  assign is_commit = (stage == MEMSTORE);
  assign clr       = is_commit | flush | restore_w;

  regfile_pending_buf #(
    .NUM_REGS   (NUM_REGS),
    .DATA_W     (DATA_W),
    .NUM_WPORTS (NUM_WPORTS)
  ) u_pend (
    .clk           (clk),
    .n_reset       (n_reset),
    .clr_i         (clr),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .merged_data_o (merged_data),
    .merged_vld_o  (merged_vld),
    .pend_vld_o    (pending_vld),
    .conflict_o    (conflict)
  );

  // Restore outranks a commit; flush during MEMSTORE suppresses the commit.
  always_comb begin
    cur_d = cur_q;
    if (restore_w) begin
      cur_d = shadow_q;
    end else if (is_commit && !flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (merged_vld[i]) cur_d[i] = merged_data[i];
      end
    end
    cnt_d = is_commit ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cur_q <= '0;
      cnt_q <= '0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end

  assign cur        = cur_q;
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_write_regfile.sv
// Directed bench for write_regfile (default parameters); shadow checks run
// only when WRITE_REGFILE_SHADOW_EN is defined.
module tb_write_regfile;
  import write_regfile_pkg::*;

  logic                 clk;
  logic                 n_reset;
  stage_t               stage;
  logic [1:0]           wr_en;
  logic [1:0][1:0]      wr_addr;
  logic [1:0][3:0]      wr_data;
  logic                 flush;
  logic                 save;
  logic                 restore;
  logic [3:0][3:0]      cur;
  logic [3:0]           pending_vld;
  logic                 conflict;
  logic [7:0]           commit_cnt;

  int n_chk;
  int n_fail;

  write_regfile #(
    .NUM_REGS   (4),
    .DATA_W     (4),
    .NUM_WPORTS (2),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .stage       (stage),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .flush       (flush),
`ifdef WRITE_REGFILE_SHADOW_EN
    .save        (save),
    .restore     (restore),
`endif
    .cur         (cur),
    .pending_vld (pending_vld),
    .conflict    (conflict),
    .commit_cnt  (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input stage_t st);
    stage   = st;
    wr_en   = 2'b00;
    wr_addr = '0;
    wr_data = '0;
    flush   = 1'b0;
    save    = 1'b0;
    restore = 1'b0;
  endtask

  task automatic wr2(input stage_t st, input logic [1:0] en,
                     input logic [1:0] a0, input logic [3:0] d0,
                     input logic [1:0] a1, input logic [3:0] d1);
    idle(st);
    wr_en      = en;
    wr_addr[0] = a0;
    wr_data[0] = d0;
    wr_addr[1] = a1;
    wr_data[1] = d1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_reset = 1'b0;
    idle(ST_FETCH);
    #3;
    check_eq("rst_cur", 32'(cur), 32'h0);
    check_eq("rst_pvld", 32'(pending_vld), 32'h0);
    check_eq("rst_conflict", 32'(conflict), 32'h0);
    check_eq("rst_cnt", 32'(commit_cnt), 32'h0);
    #4 n_reset = 1'b1;
    tick();

    // port0 r1=5 buffered, then committed
    wr2(ST_FETCH, 2'b01, 2'd1, 4'h5, 2'd0, 4'h0);
    tick();
    check_eq("pend_r1_vld", 32'(pending_vld), 32'b0010);
    check_eq("pend_r1_cur", 32'(cur), 32'h0);
    idle(MEMSTORE);
    tick();
    check_eq("commit_r1_cur", 32'(cur), 32'h0050);
    check_eq("commit_r1_pvld", 32'(pending_vld), 32'h0);
    check_eq("commit_r1_cnt", 32'(commit_cnt), 32'd1);

    // same-cycle MEMSTORE write overrides pending r2
    wr2(ST_FETCH, 2'b01, 2'd2, 4'h3, 2'd0, 4'h0);
    tick();
    check_eq("pend_r2_vld", 32'(pending_vld), 32'b0100);
    wr2(MEMSTORE, 2'b10, 2'd0, 4'h0, 2'd2, 4'hA);
    tick();
    check_eq("override_cur", 32'(cur), 32'h0A50);
    check_eq("override_pvld", 32'(pending_vld), 32'h0);
    check_eq("override_cnt", 32'(commit_cnt), 32'd2);
    check_eq("no_conflict", 32'(conflict), 32'h0);

    // both ports hit r0: port1 wins, conflict sticks
    wr2(ST_FETCH, 2'b11, 2'd0, 4'h1, 2'd0, 4'h7);
    tick();
    check_eq("conf_set", 32'(conflict), 32'h1);
    check_eq("conf_pvld", 32'(pending_vld), 32'b0001);
    idle(MEMSTORE);
    tick();
    check_eq("conf_cur", 32'(cur), 32'h0A57);
    check_eq("conf_sticky", 32'(conflict), 32'h1);
    check_eq("conf_cnt", 32'(commit_cnt), 32'd3);

    // flush outside MEMSTORE discards pending r3
    wr2(ST_FETCH, 2'b01, 2'd3, 4'hF, 2'd0, 4'h0);
    tick();
    check_eq("flush_pre_pvld", 32'(pending_vld), 32'b1000);
    idle(ST_EXEC);
    flush = 1'b1;
    tick();
    check_eq("flush_pvld", 32'(pending_vld), 32'h0);
    idle(MEMSTORE);
    tick();
    check_eq("flush_cur", 32'(cur), 32'h0A57);
    check_eq("flush_cnt", 32'(commit_cnt), 32'd4);

    // flush during MEMSTORE suppresses the commit but still counts
    wr2(ST_FETCH, 2'b01, 2'd3, 4'hF, 2'd0, 4'h0);
    tick();
    wr2(MEMSTORE, 2'b10, 2'd0, 4'h0, 2'd1, 4'hC);
    flush = 1'b1;
    tick();
    check_eq("mflush_cur", 32'(cur), 32'h0A57);
    check_eq("mflush_pvld", 32'(pending_vld), 32'h0);
    check_eq("mflush_cnt", 32'(commit_cnt), 32'd5);

    // flush drops same-cycle port writes
    wr2(ST_DECODE, 2'b01, 2'd1, 4'hC, 2'd0, 4'h0);
    flush = 1'b1;
    tick();
    check_eq("flush_drop_pvld", 32'(pending_vld), 32'h0);

    // counter wrap
    idle(MEMSTORE);
    repeat (250) tick();
    check_eq("cnt_255", 32'(commit_cnt), 32'd255);
    tick();
    check_eq("cnt_wrap", 32'(commit_cnt), 32'd0);
    check_eq("wrap_cur", 32'(cur), 32'h0A57);

`ifdef WRITE_REGFILE_SHADOW_EN
    wr2(ST_FETCH, 2'b11, 2'd0, 4'h1, 2'd1, 4'h2);
    tick();
    wr2(ST_FETCH, 2'b11, 2'd2, 4'h3, 2'd3, 4'h4);
    tick();
    idle(MEMSTORE);
    tick();
    check_eq("sh_cur_1234", 32'(cur), 32'h4321);
    idle(ST_FETCH);
    save = 1'b1;
    tick();
    wr2(ST_FETCH, 2'b11, 2'd0, 4'h9, 2'd1, 4'h9);
    tick();
    wr2(ST_FETCH, 2'b11, 2'd2, 4'h9, 2'd3, 4'h9);
    tick();
    idle(MEMSTORE);
    tick();
    check_eq("sh_cur_9999", 32'(cur), 32'h9999);
    wr2(ST_FETCH, 2'b01, 2'd0, 4'h5, 2'd0, 4'h0);
    tick();
    check_eq("sh_pend_r0", 32'(pending_vld), 32'b0001);
    idle(MEMSTORE);
    restore = 1'b1;
    tick();
    check_eq("sh_restore_cur", 32'(cur), 32'h4321);
    check_eq("sh_restore_pvld", 32'(pending_vld), 32'h0);
    check_eq("sh_restore_cnt", 32'(commit_cnt), 32'd3);
`endif

    // async reset mid-cycle with state pending
    wr2(ST_FETCH, 2'b01, 2'd1, 4'h6, 2'd0, 4'h0);
    tick();
    check_eq("pre_rst_pvld", 32'(pending_vld), 32'b0010);
    idle(ST_FETCH);
    #2 n_reset = 1'b0;
    #1;
    check_eq("mid_rst_cur", 32'(cur), 32'h0);
    check_eq("mid_rst_pvld", 32'(pending_vld), 32'h0);
    check_eq("mid_rst_conflict", 32'(conflict), 32'h0);
    check_eq("mid_rst_cnt", 32'(commit_cnt), 32'h0);
    #1 n_reset = 1'b1;
    idle(MEMSTORE);
    tick();
    check_eq("post_rst_cur", 32'(cur), 32'h0);
    check_eq("post_rst_cnt", 32'(commit_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
